// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I register file write-back path.
package rv32i_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NREGS      = 32;

  // Select for the write-port mux: which requester owns the port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EX   = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for destination registers with loads in flight, plus the
// three-port hazard lookup used by decode. Register x0 is never busy.
module wb_scoreboard
  import rv32i_pkg::*;
#(
  parameter int NR = NREGS
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_i,
  input  logic                  dec_we_i,
  output logic                  hazard_o
);

  logic [NR-1:0] busy_q;
  logic [NR-1:0] busy_d;

  // Bit 0 stays clear so x0 never stalls decode.
  assign busy_d[0] = 1'b0;

  // Per-register next state: a set in the same cycle as a clear wins, since
  // a newly issued load re-claims the register after the old one lands.
  genvar gi;
  generate
    for (gi = 1; gi < NR; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit    = set_en_i && (set_rd_i == REG_ADDR_W'(gi));
      assign clr_hit    = clr_en_i && (clr_rd_i == REG_ADDR_W'(gi));
      assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
    end
  endgenerate

  // Scoreboard flops; reset drops every in-flight load immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // RAW on either source, WAW on the destination when decode writes it.
  always_comb begin
    hazard_o = busy_q[rs1_i] | busy_q[rs2_i] | (dec_we_i & busy_q[dec_rd_i]);
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates the register file's single write port
// between execute and the LSU (with LSU starvation protection) and tracks
// load destinations for decode hazard detection.
module regfile_wb_ctrl
  import rv32i_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0]       ex_data_i,
  output logic                  ex_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  output logic                  lsu_ready_o,
  input  logic                  issue_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_i,
  input  logic                  dec_we_i,
  output logic                  hazard_o,
  output logic                  reg_write_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       write_data_o
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  wb_src_t          grant;
  logic             lsu_forced;
  logic             sb_hazard;

  // Arbitration: execute wins ties until the LSU has been refused
  // STARVE_MAX cycles in a row, then the LSU takes the port.
  always_comb begin
    lsu_forced = lsu_valid_i && (wait_cnt_q == CNT_MAX);
    grant      = WB_NONE;
    if (rst_n_i) begin
      if (lsu_valid_i && (!ex_valid_i || lsu_forced)) begin
        grant = WB_LSU;
      end else if (ex_valid_i) begin
        grant = WB_EX;
      end
    end
    ex_ready_o  = rst_n_i && !lsu_forced;
    lsu_ready_o = rst_n_i && !(lsu_valid_i && (grant == WB_EX));
  end

  // Write-port mux; a grant to x0 completes the handshake without writing.
  always_comb begin
    rd_o         = '0;
    write_data_o = '0;
    case (grant)
      WB_EX: begin
        rd_o         = ex_rd_i;
        write_data_o = ex_data_i;
      end
      WB_LSU: begin
        rd_o         = lsu_rd_i;
        write_data_o = lsu_data_i;
      end
      default: ;
    endcase
    reg_write_o = (grant != WB_NONE) && (rd_o != '0);
  end

  // Starvation counter: counts consecutive refused LSU cycles, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!lsu_valid_i || (grant == WB_LSU)) begin
      wait_cnt_d = '0;
    end else if (!lsu_ready_o && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Counter register; cleared asynchronously with the scoreboard.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  wb_scoreboard #(
    .NR(NREGS)
  ) u_scoreboard (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .set_en_i (issue_i && (issue_rd_i != '0)),
    .set_rd_i (issue_rd_i),
    .clr_en_i (grant == WB_LSU),
    .clr_rd_i (lsu_rd_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .dec_rd_i (dec_rd_i),
    .dec_we_i (dec_we_i),
    .hazard_o (sb_hazard)
  );

  // Decode never sees a stall while the block is held in reset.
  always_comb begin
    hazard_o = rst_n_i && sb_hazard;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32x32 register file. It shares the file's single write port between the execute-stage writeback and the load/store unit (LSU), with starvation protection for the LSU. It also keeps a busy scoreboard of destination registers with loads in flight, so the pipeline can stall on RAW/WAW hazards. It sits between the pipeline/LSU and the register file's `reg_write_i`/`rd_i`/`write_data_i` inputs.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREGS`, 32: architectural registers; x0 hard-wired to zero.
- `STARVE_MAX`, 4: consecutive cycles the LSU may be refused before it takes priority; must be ≥1.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `ex_valid_i`  in  1  execute stage has a writeback this cycle.
- `ex_rd_i`  in  5  execute destination register.
- `ex_data_i`  in  XLEN  execute result.
- `ex_ready_o`  out  1  execute writeback accepted; low means the pipeline must hold.
- `lsu_valid_i`  in  1  LSU load data is pending.
- `lsu_rd_i`  in  5  load destination register.
- `lsu_data_i`  in  XLEN  load data.
- `lsu_ready_o`  out  1  load writeback accepted.
- `issue_i`  in  1  a load is issued this cycle.
- `issue_rd_i`  in  5  destination of the issued load.
- `rs1_i`, `rs2_i`  in  5  source registers of the instruction in decode.
- `dec_rd_i`  in  5  destination of the instruction in decode.
- `dec_we_i`  in  1  the decode instruction writes `dec_rd_i`.
- `hazard_o`  out  1  decode must stall.
- `reg_write_o`  out  1  register file write enable.
- `rd_o`  out  5  register file write address.
- `write_data_o`  out  XLEN  register file write data.

## Operation
- State:
  - `busy[NREGS-1:0]` scoreboard; bit 0 is constant 0.
  - `wait_cnt`, width clog2(STARVE_MAX+1), saturating.
- Arbitration, combinational, each cycle:
  - **Only one requester valid:** that requester is granted.
  - **Both valid, `wait_cnt < STARVE_MAX`:** execute is granted; `lsu_ready_o`=0.
  - **Both valid, `wait_cnt == STARVE_MAX`:** LSU is granted; `ex_ready_o`=0.
  - **Neither valid:** both readies are 1 and `reg_write_o`=0.
  - A requester that is not valid still sees ready=1 unless the other requester holds a forced grant.
- Write port:
  - `reg_write_o` = a grant was issued and the granted rd is ≠ 0.
  - `rd_o` and `write_data_o` are muxed from the granted source; they are 0 when there is no grant.
  - A grant with rd=0 completes the handshake but does not write.
- `wait_cnt` update:
  - Increments when `lsu_valid_i` && !`lsu_ready_o`, saturating at STARVE_MAX.
  - Clears on an LSU grant or when `lsu_valid_i`=0.
- Scoreboard:
  - Sets `busy[issue_rd_i]` when `issue_i` is asserted and `issue_rd_i` ≠ 0.
  - Clears `busy[lsu_rd_i]` on an LSU grant.
  - If set and clear target the same register in the same cycle, the set wins.
- Hazard, combinational:
  - `hazard_o` = `busy[rs1_i]` | `busy[rs2_i]` | (`dec_we_i` & `busy[dec_rd_i]`).
  - Index 0 never contributes.
- Protocol:
  - Once asserted, `lsu_valid_i`, `lsu_rd_i` and `lsu_data_i` hold until `lsu_ready_o`.
  - `issue_i` is never asserted while `hazard_o`=1.

## Timing
- Reset, asynchronous: `busy`=0 and `wait_cnt`=0 immediately.
- While `rst_n_i`=0:
  - `reg_write_o`=0, `rd_o`=0, `write_data_o`=0.
  - `ex_ready_o`=0 and `lsu_ready_o`=0.
  - `hazard_o`=0.
- Grant and write controls are presented in the same cycle (zero latency); the register file updates on the next rising edge.
- Busy bits set or clear on the edge that ends the issue or grant cycle.
  - Because the load data lands on that same edge, `hazard_o` deasserts the cycle after the LSU grant, and the register file read returns the new value in that cycle. No bypass is needed.
- Worst-case LSU wait under continuous execute traffic: STARVE_MAX refused cycles, then a grant in the next cycle.
- Reset asserted mid-operation drops all in-flight scoreboard state; the LSU must also be reset.

## Structure
- Shared package `rv32i_pkg` holds:
  - `REG_ADDR_W` = 5, `XLEN` = 32, `NREGS` = 32.
  - An enum `wb_src_t` {WB_NONE, WB_EX, WB_LSU} for the grant mux select.
- One sub-module, `wb_scoreboard`, containing the busy vector, set/clear logic and the three-port hazard lookup.
- The arbiter and `wait_cnt` live in the top module.

## Test plan
- **Reset:** assert `rst_n_i`=0 with `ex_valid_i`=1 → `reg_write_o`=0, readies 0, `hazard_o`=0. Release with ex rd=5, data=0xDEADBEEF → `reg_write_o`=1, `rd_o`=5 the same cycle.
- **Load scoreboard:** issue load rd=7; decode `rs1_i`=7 → `hazard_o`=1. LSU grant for rd=7, data=0x12345678 → `hazard_o`=0 the next cycle; x7 reads 0x12345678.
- **Starvation:** `ex_valid_i` held high, LSU valid rd=3 with STARVE_MAX=4 → LSU refused for 4 cycles; the 5th cycle has `lsu_ready_o`=1, `ex_ready_o`=0, `rd_o`=3.
- **x0 handling:** issue load rd=0 → no busy bit set, `hazard_o`=0 for rs1=0. LSU rd=0 granted → `reg_write_o`=0, `lsu_ready_o`=1.
- **Simultaneous set/clear:** LSU grant rd=9 in the same cycle as issue rd=9 → `busy[9]`=1 afterwards, so `hazard_o`=1 for `rs2_i`=9.
- **Reset mid-operation:** busy bits 4 and 6 set, `wait_cnt`=3; pulse `rst_n_i` low between edges → all busy bits clear and `wait_cnt`=0 immediately, without waiting for a clock edge.
